// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester arbiter sequencing a single-port data memory
module dm_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int CPU_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        cnt_q;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              owner_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] aux_rdata_q;
    logic              any_req;
    logic              grant_aux;
    logic              rd_done;

    assign any_req = cpu_req | aux_req;
    assign rd_done = (state_q == S_WAIT) && (cnt_q == LAT);

    // Winner selection: a lone requester wins; a tie goes to the CPU or to the port that did not own last.
    always_comb begin
        grant_aux = aux_req;
        if (cpu_req && aux_req) begin
            grant_aux = (CPU_PRIO != 0) ? 1'b0 : ~owner_q;
        end
    end

    // Next-state logic for the grant/issue/wait/done sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = lat_we ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt_q == LAT) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset mid-access simply abandons the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winning request in the grant cycle; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state_q == S_IDLE && any_req) begin
            owner_q   <= grant_aux;
            lat_we    <= grant_aux ? aux_we    : cpu_we;
            lat_addr  <= grant_aux ? aux_addr  : cpu_addr;
            lat_wdata <= grant_aux ? aux_wdata : cpu_wdata;
        end
    end

    // Read latency counter: starts at 1 in the first wait cycle, stops at the configured latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 3'd0;
        end else if (state_q == S_ISSUE) begin
            cnt_q <= 3'd1;
        end else if (state_q == S_WAIT && cnt_q != LAT) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // Per-port read data, held until the next read for that port completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else if (rd_done) begin
            if (owner_q) begin
                aux_rdata_q <= mem_rdata;
            end else begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = mem_en ? lat_addr  : '0;
    assign mem_wdata = mem_en ? lat_wdata : '0;

    assign cpu_ack   = (state_q == S_DONE) & ~owner_q;
    assign aux_ack   = (state_q == S_DONE) &  owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign aux_rdata = aux_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed vector bench for dm_arbiter
module tb_dm_arbiter;

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [10:0] caddr;
        logic [31:0] cwd;
        logic        areq;
        logic        awe;
        logic [10:0] aaddr;
        logic [31:0] awd;
        logic        men;
        logic        mwe;
        logic [10:0] maddr;
        logic [31:0] mwd;
        logic        cack;
        logic        aack;
        logic        cstall;
        logic        busy;
        logic        own;
        logic [31:0] crd;
        logic [31:0] ard;
    } vec_t;

    logic        clk;
    logic        rst   [2];
    logic        creq  [2];
    logic        cwe   [2];
    logic [10:0] caddr [2];
    logic [31:0] cwd   [2];
    logic        areq  [2];
    logic        awe   [2];
    logic [10:0] aaddr [2];
    logic [31:0] awd   [2];
    logic        cack  [2];
    logic        aack  [2];
    logic        cstall[2];
    logic [31:0] crd   [2];
    logic [31:0] ard   [2];
    logic        men   [2];
    logic        mwe   [2];
    logic [10:0] maddr [2];
    logic [31:0] mwd   [2];
    logic        busy  [2];
    logic        own   [2];

    logic [31:0] ram  [2][2048];
    logic [31:0] pipe [2][3];

    int n_pass;
    int n_total;

    vec_t tv[16];

    dm_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(1), .CPU_PRIO(0)) u0 (
        .clk(clk), .rst(rst[0]),
        .cpu_req(creq[0]), .cpu_we(cwe[0]), .cpu_addr(caddr[0]), .cpu_wdata(cwd[0]),
        .cpu_ack(cack[0]), .cpu_rdata(crd[0]), .cpu_stall(cstall[0]),
        .aux_req(areq[0]), .aux_we(awe[0]), .aux_addr(aaddr[0]), .aux_wdata(awd[0]),
        .aux_ack(aack[0]), .aux_rdata(ard[0]),
        .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .mem_rdata(pipe[0][0]), .busy(busy[0]), .owner(own[0])
    );

    dm_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(3), .CPU_PRIO(1)) u1 (
        .clk(clk), .rst(rst[1]),
        .cpu_req(creq[1]), .cpu_we(cwe[1]), .cpu_addr(caddr[1]), .cpu_wdata(cwd[1]),
        .cpu_ack(cack[1]), .cpu_rdata(crd[1]), .cpu_stall(cstall[1]),
        .aux_req(areq[1]), .aux_we(awe[1]), .aux_addr(aaddr[1]), .aux_wdata(awd[1]),
        .aux_ack(aack[1]), .aux_rdata(ard[1]),
        .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .mem_rdata(pipe[1][2]), .busy(busy[1]), .owner(own[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 2048; a++) begin
                ram[p][a] <= 32'h0;
            end
        end
    end

    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (men[p] && mwe[p]) ram[p][maddr[p]] <= mwd[p];
            pipe[p][0] <= (men[p] && !mwe[p]) ? ram[p][maddr[p]] : 32'h0;
            pipe[p][1] <= pipe[p][0];
            pipe[p][2] <= pipe[p][1];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs(input int p);
        creq[p] = 1'b0; cwe[p] = 1'b0; caddr[p] = 11'h0; cwd[p] = 32'h0;
        areq[p] = 1'b0; awe[p] = 1'b0; aaddr[p] = 11'h0; awd[p] = 32'h0;
    endtask

    task automatic get_lat(input int p, input bit port_aux, output int lat);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (port_aux ? aack[p] : cack[p]) begin
                lat = k;
                break;
            end
            next_cycle();
        end
    endtask

    task automatic chk_reset(input string name, input int p);
        chk(name, {men[p], mwe[p], maddr[p], mwd[p], cack[p], aack[p], busy[p], own[p], crd[p], ard[p]},
            {1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
    endtask

    initial begin
        logic [31:0] db;
        logic [31:0] d2;
        int order[$];
        int ack_cyc[$];
        int coinc;
        int consec;
        int nc;
        int na;
        int lat;
        logic prev_men;
        int exp_order[4];
        int exp_cyc[4];

        db = 32'hDEADBEEF;
        d2 = 32'h12345678;
        n_pass = 0;
        n_total = 0;

        tv[0]  = '{1'b1,1'b1,11'h010,db, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0,32'h0};
        tv[1]  = '{1'b1,1'b1,11'h010,db, 1'b0,1'b0,11'h000,32'h0, 1'b1,1'b1,11'h010,db,    1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0,32'h0};
        tv[2]  = '{1'b1,1'b1,11'h010,db, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b1,1'b0,1'b0,1'b1,1'b0, 32'h0,32'h0};
        tv[3]  = '{1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,32'h0};
        tv[4]  = '{1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0,32'h0};
        tv[5]  = '{1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0,32'h0};
        tv[6]  = '{1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b1,1'b0,1'b0,1'b1,1'b0, db,32'h0};
        tv[7]  = '{1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0, db,32'h0};
        tv[8]  = '{1'b0,1'b0,11'h000,32'h0, 1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0, db,32'h0};
        tv[9]  = '{1'b0,1'b0,11'h000,32'h0, 1'b1,1'b0,11'h010,32'h0, 1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,1'b0,1'b1,1'b1, db,32'h0};
        tv[10] = '{1'b0,1'b0,11'h000,32'h0, 1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,1'b0,1'b1,1'b1, db,32'h0};
        tv[11] = '{1'b0,1'b0,11'h000,32'h0, 1'b1,1'b0,11'h010,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b1,1'b0,1'b1,1'b1, db,db};
        tv[12] = '{1'b0,1'b0,11'h000,32'h0, 1'b1,1'b1,11'h020,d2,   1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b1, db,db};
        tv[13] = '{1'b0,1'b0,11'h000,32'h0, 1'b1,1'b1,11'h030,d2,   1'b1,1'b1,11'h020,d2,    1'b0,1'b0,1'b0,1'b1,1'b1, db,db};
        tv[14] = '{1'b0,1'b0,11'h000,32'h0, 1'b1,1'b1,11'h030,d2,   1'b0,1'b0,11'h000,32'h0, 1'b0,1'b1,1'b0,1'b1,1'b1, db,db};
        tv[15] = '{1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,11'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b1, db,db};

        clear_inputs(0);
        clear_inputs(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (2) next_cycle();
        chk_reset("reset_u0", 0);
        chk_reset("reset_u1", 1);
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        for (int i = 0; i < 16; i++) begin
            creq[0] = tv[i].creq; cwe[0] = tv[i].cwe; caddr[0] = tv[i].caddr; cwd[0] = tv[i].cwd;
            areq[0] = tv[i].areq; awe[0] = tv[i].awe; aaddr[0] = tv[i].aaddr; awd[0] = tv[i].awd;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {men[0], mwe[0], maddr[0], mwd[0], cack[0], aack[0], cstall[0], busy[0], own[0], crd[0], ard[0]},
                {tv[i].men, tv[i].mwe, tv[i].maddr, tv[i].mwd, tv[i].cack, tv[i].aack,
                 tv[i].cstall, tv[i].busy, tv[i].own, tv[i].crd, tv[i].ard});
            next_cycle();
        end
        clear_inputs(0);
        chk("ram_0x020", ram[0][11'h020], d2);
        chk("ram_0x030", ram[0][11'h030], 32'h0);

        rst[0] = 1'b0;
        next_cycle();
        rst[0] = 1'b1;
        creq[0] = 1'b1; cwe[0] = 1'b1; caddr[0] = 11'h040; cwd[0] = 32'h0000000C;
        areq[0] = 1'b1; awe[0] = 1'b1; aaddr[0] = 11'h050; awd[0] = 32'h0000000A;
        coinc = 0;
        consec = 0;
        prev_men = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cack[0] && aack[0]) coinc++;
            if (men[0] && prev_men) consec++;
            prev_men = men[0];
            if (cack[0]) begin order.push_back(0); ack_cyc.push_back(k); end
            if (aack[0]) begin order.push_back(1); ack_cyc.push_back(k); end
            next_cycle();
        end
        clear_inputs(0);
        exp_order = '{0, 1, 0, 1};
        exp_cyc   = '{2, 5, 8, 11};
        chk("rr_ack_count", order.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), (i < order.size()) ? order[i] : 9, exp_order[i]);
            chk($sformatf("rr_cycle%0d", i), (i < ack_cyc.size()) ? ack_cyc[i] : 99, exp_cyc[i]);
        end
        chk("rr_ack_coincide", coinc, 0);
        chk("rr_mem_en_consec", consec, 0);

        creq[1] = 1'b1; cwe[1] = 1'b1; caddr[1] = 11'h010; cwd[1] = db;
        get_lat(1, 1'b0, lat);
        chk("lat3_wr_latency", lat, 2);
        next_cycle();
        cwe[1] = 1'b0; cwd[1] = 32'h0;
        get_lat(1, 1'b0, lat);
        chk("lat3_rd_latency", lat, 5);
        chk("lat3_rd_data", crd[1], db);
        next_cycle();

        creq[1] = 1'b1; cwe[1] = 1'b1; caddr[1] = 11'h060; cwd[1] = 32'h1;
        areq[1] = 1'b1; awe[1] = 1'b1; aaddr[1] = 11'h070; awd[1] = 32'h2;
        nc = 0;
        na = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (cack[1]) nc++;
            if (aack[1]) na++;
            next_cycle();
        end
        chk("prio_cpu_acks", nc, 3);
        chk("prio_aux_acks", na, 0);
        creq[1] = 1'b0;
        get_lat(1, 1'b1, lat);
        chk("prio_aux_latency", lat, 2);
        next_cycle();
        clear_inputs(1);
        next_cycle();
        chk("prio_aux_write", ram[1][11'h070], 32'h2);

        creq[1] = 1'b1; cwe[1] = 1'b0; caddr[1] = 11'h010;
        next_cycle();
        next_cycle();
        chk("rst_wait_busy", busy[1], 1'b1);
        rst[1] = 1'b0;
        #1;
        chk_reset("rst_in_wait", 1);
        creq[1] = 1'b0;
        next_cycle();
        rst[1] = 1'b1;
        na = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cack[1] || aack[1]) na++;
            next_cycle();
        end
        chk("rst_no_ack", na, 0);
        creq[1] = 1'b1;
        get_lat(1, 1'b0, lat);
        chk("rst_after_latency", lat, 5);
        chk("rst_after_data", crd[1], db);
        next_cycle();
        clear_inputs(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
